// File: rtl/ray_gen.sv
// rtl/ray_gen.sv - camera primary-ray generator: one ray per pixel, raster order, valid/ready out.
// Optional RAYGEN_SAT_EN: direction components saturate instead of wrapping.
module ray_gen #(
   parameter int XY_BITS  = 12,
   parameter int FRA_BITS = 16
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_start,
   input  logic [XY_BITS-1:0] i_width,
   input  logic [XY_BITS-1:0] i_height,
   input  logic [95:0]        i_eye,
   input  logic [95:0]        i_dir0,
   input  logic [95:0]        i_du,
   input  logic [95:0]        i_dv,
   output logic [191:0]       o_ray,
   output logic [XY_BITS-1:0] o_x,
   output logic [XY_BITS-1:0] o_y,
   output logic               o_valid,
   input  logic               i_ready,
   output logic               o_busy,
   output logic               o_done
);

   localparam int CW = 2 * FRA_BITS;
   localparam logic [XY_BITS-1:0] ONE = XY_BITS'(1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             state_q, state_d;
   logic [95:0]        eye_q, eye_d, du_q, du_d, dv_q, dv_d;
   logic [95:0]        row_q, row_d, cur_q, cur_d;
   logic [XY_BITS-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
   logic               done_q, done_d;

   // Same-sign operands whose sum flips sign have overflowed.
   function automatic logic [CW-1:0] acc(input logic [CW-1:0] a, input logic [CW-1:0] b);
      logic [CW-1:0] s;
      s = a + b;
`ifdef RAYGEN_SAT_EN
      if ((a[CW-1] == b[CW-1]) && (s[CW-1] != a[CW-1]))
         s = a[CW-1] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
`endif
      return s;
   endfunction

   function automatic logic [95:0] acc3(input logic [95:0] a, input logic [95:0] b);
      return {acc(a[95:64], b[95:64]), acc(a[63:32], b[63:32]), acc(a[31:0], b[31:0])};
   endfunction

   always_comb begin
      state_d = state_q;
      eye_d   = eye_q;
      du_d    = du_q;
      dv_d    = dv_q;
      row_d   = row_q;
      cur_d   = cur_q;
      x_d     = x_q;
      y_d     = y_q;
      w_d     = w_q;
      h_d     = h_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               if ((i_width == '0) || (i_height == '0)) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_RUN;
                  eye_d   = i_eye;
                  du_d    = i_du;
                  dv_d    = i_dv;
                  row_d   = i_dir0;
                  cur_d   = i_dir0;
                  x_d     = '0;
                  y_d     = '0;
                  w_d     = i_width;
                  h_d     = i_height;
               end
            end
         end
         S_RUN: begin
            if (i_ready) begin
               if (x_q != w_q - ONE) begin
                  x_d   = x_q + ONE;
                  cur_d = acc3(cur_q, du_q);
               end else if (y_q != h_q - ONE) begin
                  // Next row restarts from the row base, not from the end of this row.
                  x_d   = '0;
                  y_d   = y_q + ONE;
                  row_d = acc3(row_q, dv_q);
                  cur_d = acc3(row_q, dv_q);
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q <= S_IDLE;
         eye_q   <= '0;
         du_q    <= '0;
         dv_q    <= '0;
         row_q   <= '0;
         cur_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         w_q     <= '0;
         h_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         eye_q   <= eye_d;
         du_q    <= du_d;
         dv_q    <= dv_d;
         row_q   <= row_d;
         cur_q   <= cur_d;
         x_q     <= x_d;
         y_q     <= y_d;
         w_q     <= w_d;
         h_q     <= h_d;
         done_q  <= done_d;
      end
   end

   assign o_ray   = {cur_q, eye_q};
   assign o_x     = x_q;
   assign o_y     = y_q;
   assign o_valid = (state_q == S_RUN);
   assign o_busy  = (state_q == S_RUN);
   assign o_done  = done_q;

endmodule
